exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the pipelined CPU, placed directly after the ID/EXE pipeline register and consuming its registered outputs. Selects ALU operands, performs single-cycle ALU operations, and runs an iterative 32-step multiply/divide unit that writes the HI/LO registers. Drives the EXE/MEM pipeline register (internal) and a `stall_out` that freezes PC, IF/ID and ID/EXE while the multiply/divide unit is busy.

## Interface
Parameters:
- `MD_STEPS`, 32: iterations per multiply/divide; fixed at 32 for the 32-bit datapath.

Ports:
- Clock and reset: `clk` is the single clock. `rst` is asynchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous reset, active-high
- `WriteDataSrc_in`  in  2  00 ALU, 01 MEM, 10 HI, 11 LO
- `DataMemWE_in`  in  1  store enable
- `alu_op_in`  in  4  operation code (see Operation)
- `ALUopnd1src_in`  in  2  00 reg1data, 01 {27'b0,sa}, 10/11 zero
- `ALUopnd2src_in`  in  2  00 reg2data, 01 extended_data, 10/11 zero
- `reg1data_in`, `reg2data_in`, `extended_data_in`  in  32  operands
- `reg_write_addr_in`, `sa_in`  in  5  destination register, shift amount
- `WriteDataSrc_out`  out  2  registered copy
- `DataMemWE_out`  out  1  registered; 0 on bubble
- `alu_result_out`  out  32  registered ALU/HI/LO result
- `store_data_out`  out  32  registered reg2data
- `reg_write_addr_out`  out  5  registered; 0 on bubble
- `stall_out`  out  1  high while multiply/divide is busy

## Operation
- The `alu_op` codes are as follows:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLL, 7 SRL, 8 SRA: `B` shifted by `A[4:0]`.
  - 9 SLT (signed), 10 SLTU: result 0 or 1.
  - 11 LUI: `B<<16`.
  - 12 MULT, 13 MULTU, 14 DIV, 15 DIVU.
- Operand A is selected by `ALUopnd1src`; operand B is selected by `ALUopnd2src`. Arithmetic is 32-bit and wraps; no overflow trap.
- Result mux: WriteDataSrc 10 selects HI and 11 selects LO. Otherwise the ALU result is used.
- Multiply/divide state machine has two states, IDLE and BUSY, with step counter 0..31:
  - IDLE, op 12–15: latch the operand magnitudes and sign flags, then go to BUSY.
  - BUSY: one shift-add step (multiply) or one restoring step (divide) per cycle.
  - After step 31, sign-correct the result, write HI/LO, and return to IDLE.
- MULT/MULTU: {HI,LO} = 64-bit product (signed or unsigned).
- DIV/DIVU: LO = quotient, HI = remainder. Quotient truncates toward zero, and the remainder takes the sign of the dividend.
- Divide by zero: LO = 0xFFFFFFFF, HI = dividend.
- Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `stall_out` = (state == BUSY). While stall is high, the EXE/MEM output register loads a bubble: all control fields 0, `reg_write_addr_out` = 0, `DataMemWE_out` = 0.
- The mul/div instruction itself produces a bubble in EXE/MEM, since it has no register-file write.
- An op 12–15 arriving while BUSY cannot occur, because the upstream stages are frozen.

## Timing
- ALU ops: result appears at the EXE/MEM outputs one clock after the input is presented.
- Mul/div accepted at edge 0. `stall_out` is high during cycles 1..32. HI/LO are written at edge 32, and `stall_out` is low in cycle 33.
- The instruction held in ID/EXE during the stall reads the new HI/LO in cycle 33 (mfhi/mflo hazard-free).
- Reset, asserted at any time including mid-BUSY:
  - All outputs are 0 and `stall_out` is 0.
  - HI, LO and the counter are 0, and the state machine is IDLE.
  - The partial result is discarded.

## Structure
- The op codes, WriteDataSrc codes, operand-source codes and zero constants are defined in the shared `const.vh`.
- Sub-module `mul_div_unit`: holds the iterative state machine, counter and HI/LO registers.
  - Inputs: start, op, a, b.
  - Outputs: busy, hi, lo.
- The top level contains the operand muxes, the combinational ALU and the EXE/MEM register.

## Test plan
- ADD with opnd2src=01, reg1=0x00000005, ext=0xFFFFFFFE → next cycle `alu_result_out` = 0x00000003, and `reg_write_addr_out` matches the input.
- SRA with opnd1src=01, sa=4, reg2=0x80000000 → 0xF8000000. SLT with 0xFFFFFFFF vs 1 → 1; SLTU on the same operands → 0.
- MULT 0xFFFFFFFE × 3 → `stall_out` high exactly 32 cycles, then HI = 0xFFFFFFFF and LO = 0xFFFFFFFA. A following mflo (WriteDataSrc=11) returns 0xFFFFFFFA.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU x / 0 → LO = 0xFFFFFFFF, HI = x. Signed 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- Assert `rst` at busy cycle 10 → `stall_out` drops immediately, outputs and HI/LO read 0, and the next ALU op proceeds normally.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: op codes, mux selects and the EXE/MEM payload.
package exe_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_AW    = 5;
    localparam logic [XLEN-1:0] ZERO_WORD = '0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,  ALU_SUB   = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,  ALU_NOR   = 4'd5,  ALU_SLL  = 4'd6,  ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,  ALU_SLT   = 4'd9,  ALU_SLTU = 4'd10, ALU_LUI  = 4'd11,
        ALU_MULT = 4'd12, ALU_MULTU = 4'd13, ALU_DIV  = 4'd14, ALU_DIVU = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        WDS_ALU = 2'b00, WDS_MEM = 2'b01, WDS_HI = 2'b10, WDS_LO = 2'b11
    } wds_e;

    localparam logic [1:0] OPND1_REG = 2'b00;
    localparam logic [1:0] OPND1_SA  = 2'b01;
    localparam logic [1:0] OPND2_REG = 2'b00;
    localparam logic [1:0] OPND2_EXT = 2'b01;

    typedef struct packed {
        logic [1:0]        write_data_src;
        logic              data_mem_we;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   store_data;
        logic [REG_AW-1:0] reg_write_addr;
    } exe_mem_t;

    // Ops 12..15 go to the iterative multiply/divide unit.
    function automatic logic is_md_op(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE inputs and EXE/MEM outputs of the execute stage.
interface exe_stage_if;
    logic [1:0]  WriteDataSrc_in;
    logic        DataMemWE_in;
    logic [3:0]  alu_op_in;
    logic [1:0]  ALUopnd1src_in;
    logic [1:0]  ALUopnd2src_in;
    logic [31:0] reg1data_in;
    logic [31:0] reg2data_in;
    logic [31:0] extended_data_in;
    logic [4:0]  reg_write_addr_in;
    logic [4:0]  sa_in;
    logic [1:0]  WriteDataSrc_out;
    logic        DataMemWE_out;
    logic [31:0] alu_result_out;
    logic [31:0] store_data_out;
    logic [4:0]  reg_write_addr_out;
    logic        stall_out;

    modport master (
        output WriteDataSrc_in, DataMemWE_in, alu_op_in, ALUopnd1src_in, ALUopnd2src_in,
               reg1data_in, reg2data_in, extended_data_in, reg_write_addr_in, sa_in,
        input  WriteDataSrc_out, DataMemWE_out, alu_result_out, store_data_out,
               reg_write_addr_out, stall_out
    );

    modport slave (
        input  WriteDataSrc_in, DataMemWE_in, alu_op_in, ALUopnd1src_in, ALUopnd2src_in,
               reg1data_in, reg2data_in, extended_data_in, reg_write_addr_in, sa_in,
        output WriteDataSrc_out, DataMemWE_out, alu_result_out, store_data_out,
               reg_write_addr_out, stall_out
    );
endinterface

// File: rtl/exe_stage_mul_div_unit.sv
// Iterative multiply/divide: magnitudes processed one bit per cycle, sign fixed on the last step.
module mul_div_unit
    import exe_stage_pkg::*;
#(
    parameter int unsigned MD_STEPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int unsigned CNT_W = $clog2(MD_STEPS);

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    md_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
    logic            div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;

    logic            signed_op, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b, step_hi, step_lo;
    logic [XLEN:0]   sum, rem_sh;
    logic [XLEN+1:0] diff;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;

        signed_op = ~op[0];
        a_neg     = signed_op & a[XLEN-1];
        b_neg     = signed_op & b[XLEN-1];
        mag_a     = a_neg ? -a : a;
        mag_b     = b_neg ? -b : b;

        // Multiply: shift-add into the upper half; divide: restoring step on {rem, quotient}.
        sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : (XLEN+1)'(0));
        rem_sh = {acc_hi_q, acc_lo_q[XLEN-1]};
        diff   = {1'b0, rem_sh} - {2'b00, opnd_q};
        if (div_q) begin
            step_hi = diff[XLEN+1] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
            step_lo = {acc_lo_q[XLEN-2:0], ~diff[XLEN+1]};
        end else begin
            step_hi = sum[XLEN:1];
            step_lo = {sum[0], acc_lo_q[XLEN-1:1]};
        end
        prod = neg_lo_q ? -{step_hi, step_lo} : {step_hi, step_lo};

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d  = MD_BUSY;
                    cnt_d    = '0;
                    div_d    = op[1];
                    acc_hi_d = '0;
                    acc_lo_d = op[1] ? mag_a : mag_b;
                    opnd_d   = op[1] ? mag_b : mag_a;
                    // A zero divisor keeps the all-ones quotient unsigned.
                    neg_lo_d = (a_neg ^ b_neg) & ~(op[1] & (b == ZERO_WORD));
                    neg_hi_d = op[1] & a_neg;
                end
            end
            MD_BUSY: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MD_STEPS - 1)) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                    if (div_q) begin
                        lo_d = neg_lo_q ? -step_lo : step_lo;
                        hi_d = neg_hi_q ? -step_hi : step_hi;
                    end else begin
                        hi_d = prod[2*XLEN-1:XLEN];
                        lo_d = prod[XLEN-1:0];
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
        end
    end

    assign busy = (state_q == MD_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand muxes, single-cycle ALU, mul/div unit and the EXE/MEM register.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int unsigned MD_STEPS = 32
) (
    input logic        clk,
    input logic        rst,
    exe_stage_if.slave bus
);
    logic [XLEN-1:0] opnd_a, opnd_b, alu_res, md_hi, md_lo;
    logic            md_busy, md_op, md_start;
    exe_mem_t        exe_mem_q, exe_mem_d;

    assign md_op    = is_md_op(bus.alu_op_in);
    assign md_start = md_op & ~md_busy;

    always_comb begin
        opnd_a = ZERO_WORD;
        opnd_b = ZERO_WORD;
        if (bus.ALUopnd1src_in == OPND1_REG)      opnd_a = bus.reg1data_in;
        else if (bus.ALUopnd1src_in == OPND1_SA)  opnd_a = {27'd0, bus.sa_in};
        if (bus.ALUopnd2src_in == OPND2_REG)      opnd_b = bus.reg2data_in;
        else if (bus.ALUopnd2src_in == OPND2_EXT) opnd_b = bus.extended_data_in;
    end

    always_comb begin
        alu_res = ZERO_WORD;
        case (alu_op_e'(bus.alu_op_in))
            ALU_ADD:  alu_res = opnd_a + opnd_b;
            ALU_SUB:  alu_res = opnd_a - opnd_b;
            ALU_AND:  alu_res = opnd_a & opnd_b;
            ALU_OR:   alu_res = opnd_a | opnd_b;
            ALU_XOR:  alu_res = opnd_a ^ opnd_b;
            ALU_NOR:  alu_res = ~(opnd_a | opnd_b);
            ALU_SLL:  alu_res = opnd_b << opnd_a[4:0];
            ALU_SRL:  alu_res = opnd_b >> opnd_a[4:0];
            ALU_SRA:  alu_res = XLEN'($signed(opnd_b) >>> opnd_a[4:0]);
            ALU_SLT:  alu_res = {31'd0, $signed(opnd_a) < $signed(opnd_b)};
            ALU_SLTU: alu_res = {31'd0, opnd_a < opnd_b};
            ALU_LUI:  alu_res = opnd_b << 16;
            default:  alu_res = ZERO_WORD;
        endcase
    end

    mul_div_unit #(.MD_STEPS(MD_STEPS)) u_mul_div (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .op    (bus.alu_op_in[1:0]),
        .a     (opnd_a),
        .b     (opnd_b),
        .busy  (md_busy),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // Stalled cycles and the mul/div instruction itself leave a bubble in EXE/MEM.
    always_comb begin
        exe_mem_d = '0;
        if (!(md_busy || md_op)) begin
            exe_mem_d.write_data_src = bus.WriteDataSrc_in;
            exe_mem_d.data_mem_we    = bus.DataMemWE_in;
            exe_mem_d.store_data     = bus.reg2data_in;
            exe_mem_d.reg_write_addr = bus.reg_write_addr_in;
            case (wds_e'(bus.WriteDataSrc_in))
                WDS_HI:  exe_mem_d.alu_result = md_hi;
                WDS_LO:  exe_mem_d.alu_result = md_lo;
                default: exe_mem_d.alu_result = alu_res;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) exe_mem_q <= '0;
        else     exe_mem_q <= exe_mem_d;
    end

    assign bus.WriteDataSrc_out   = exe_mem_q.write_data_src;
    assign bus.DataMemWE_out      = exe_mem_q.data_mem_we;
    assign bus.alu_result_out     = exe_mem_q.alu_result;
    assign bus.store_data_out     = exe_mem_q.store_data;
    assign bus.reg_write_addr_out = exe_mem_q.reg_write_addr;
    assign bus.stall_out          = md_busy;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: driver pushes expected EXE/MEM records, monitor pops and compares.
module tb_exe_stage;
    localparam int unsigned MD_STEPS = 32;

    typedef struct {
        logic [1:0]  wds;
        logic        we;
        logic [3:0]  op;
        logic [1:0]  s1, s2;
        logic [31:0] r1, r2, ext;
        logic [4:0]  wa, sa;
    } instr_t;

    typedef struct {
        logic [1:0]  wds;
        logic        we;
        logic [31:0] res, st;
        logic [4:0]  wa;
        logic        stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_stage_if bus();
    exe_stage #(.MD_STEPS(MD_STEPS)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    int          md_left = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic instr_t mk(input logic [3:0] op, input logic [1:0] wds, input logic [1:0] s1,
                                  input logic [1:0] s2, input logic [31:0] r1, input logic [31:0] r2,
                                  input logic [31:0] ext, input logic [4:0] sa, input logic [4:0] wa);
        instr_t i;
        i.op = op; i.wds = wds; i.s1 = s1; i.s2 = s2; i.r1 = r1; i.r2 = r2;
        i.ext = ext; i.sa = sa; i.wa = wa; i.we = 1'b0;
        return i;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(40));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] sel_a(input instr_t i);
        return (i.s1 == 2'd0) ? i.r1 : (i.s1 == 2'd1) ? {27'd0, i.sa} : 32'd0;
    endfunction

    function automatic logic [31:0] sel_b(input instr_t i);
        return (i.s2 == 2'd0) ? i.r2 : (i.s2 == 2'd1) ? i.ext : 32'd0;
    endfunction

    function automatic logic [31:0] alu_model(input instr_t i);
        logic [31:0] a, b;
        int sh;
        a = sel_a(i);
        b = sel_b(i);
        sh = int'(a % 32);
        case (i.op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ~(a | b);
            6: return b << sh;
            7: return b >> sh;
            8: return 32'($signed(b) >>> sh);
            9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            10: return (a < b) ? 32'd1 : 32'd0;
            11: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    // HI/LO reference from the architectural definitions of multiply and divide.
    task automatic md_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa64, sb64, sp;
        logic [63:0] up;
        sa64 = $signed(a);
        sb64 = $signed(b);
        case (op)
            12: begin sp = sa64 * sb64; {m_hi, m_lo} = 64'(sp); end
            13: begin up = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = up; end
            14: begin
                if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 32'd0; end
                else begin m_lo = 32'(sa64 / sb64); m_hi = 32'(sa64 % sb64); end
            end
            default: begin
                if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
        endcase
    endtask

    task automatic drive(input instr_t i);
        bus.WriteDataSrc_in   = i.wds;
        bus.DataMemWE_in      = i.we;
        bus.alu_op_in         = i.op;
        bus.ALUopnd1src_in    = i.s1;
        bus.ALUopnd2src_in    = i.s2;
        bus.reg1data_in       = i.r1;
        bus.reg2data_in       = i.r2;
        bus.extended_data_in  = i.ext;
        bus.reg_write_addr_in = i.wa;
        bus.sa_in             = i.sa;
    endtask

    // Presents one instruction; while the model says mul/div is busy it is held and bubbles are expected.
    task automatic issue(input instr_t i);
        bit   again;
        exp_t e;
        do begin
            @(negedge clk);
            drive(i);
            again = 1'b0;
            e.wds = 2'd0; e.we = 1'b0; e.res = 32'd0; e.st = 32'd0; e.wa = 5'd0; e.stall = 1'b0;
            if (md_left > 0) begin
                md_left--;
                e.stall = (md_left > 0);
                again = 1'b1;
            end else if (i.op >= 4'd12) begin
                md_model(i.op, sel_a(i), sel_b(i));
                md_left = MD_STEPS;
                e.stall = 1'b1;
            end else begin
                e.wds = i.wds;
                e.we  = i.we;
                e.res = (i.wds == 2'b10) ? m_hi : (i.wds == 2'b11) ? m_lo : alu_model(i);
                e.st  = i.r2;
                e.wa  = i.wa;
            end
            sbq.push_back(e);
        end while (again);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && sbq.size() > 0) begin
                e = sbq.pop_front();
                check("alu_result", bus.alu_result_out, e.res);
                check("reg_write_addr", 32'(bus.reg_write_addr_out), 32'(e.wa));
                check("write_data_src", 32'(bus.WriteDataSrc_out), 32'(e.wds));
                check("data_mem_we", 32'(bus.DataMemWE_out), 32'(e.we));
                check("store_data", bus.store_data_out, e.st);
                check("stall", 32'(bus.stall_out), 32'(e.stall));
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_stall"}, 32'(bus.stall_out), 32'd0);
        check({tag, "_result"}, bus.alu_result_out, 32'd0);
        check({tag, "_waddr"}, 32'(bus.reg_write_addr_out), 32'd0);
        check({tag, "_we"}, 32'(bus.DataMemWE_out), 32'd0);
        check({tag, "_wds"}, 32'(bus.WriteDataSrc_out), 32'd0);
        check({tag, "_store"}, bus.store_data_out, 32'd0);
    endtask

    initial begin : stimulus
        instr_t mfhi, mflo, it;
        mfhi = mk(4'd0, 2'b10, 2'd2, 2'd2, 32'd0, 32'd0, 32'd0, 5'd0, 5'd9);
        mflo = mk(4'd0, 2'b11, 2'd2, 2'd2, 32'd0, 32'd0, 32'd0, 5'd0, 5'd8);
        rst = 1'b1;
        drive(mfhi);
        #1;
        check_zero_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        it = mk(4'd0, 2'b00, 2'd0, 2'd1, 32'h5, 32'h1234, 32'hFFFF_FFFE, 5'd0, 5'd7);
        it.we = 1'b1;
        issue(it);
        issue(mk(4'd8, 2'b00, 2'd1, 2'd0, 32'h0, 32'h8000_0000, 32'h0, 5'd4, 5'd3));
        issue(mk(4'd9, 2'b00, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0, 5'd4));
        issue(mk(4'd10, 2'b00, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0, 5'd5));
        issue(mk(4'd11, 2'b01, 2'd2, 2'd1, 32'h0, 32'h0, 32'h0000_ABCD, 5'd0, 5'd6));
        issue(mk(4'd12, 2'b00, 2'd0, 2'd0, 32'hFFFF_FFFE, 32'h3, 32'h0, 5'd0, 5'd0));
        issue(mflo);
        issue(mfhi);
        issue(mk(4'd14, 2'b00, 2'd0, 2'd0, 32'hFFFF_FFF9, 32'h2, 32'h0, 5'd0, 5'd0));
        issue(mflo);
        issue(mfhi);
        issue(mk(4'd15, 2'b00, 2'd0, 2'd2, 32'h1357_9BDF, 32'h0, 32'h0, 5'd0, 5'd0));
        issue(mflo);
        issue(mfhi);
        issue(mk(4'd14, 2'b00, 2'd0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0));
        issue(mflo);
        issue(mfhi);
        issue(mk(4'd14, 2'b00, 2'd0, 2'd0, 32'hFFFF_FFF9, 32'h0, 32'h0, 5'd0, 5'd0));
        issue(mflo);
        issue(mfhi);

        for (int n = 0; n < 300; n++) begin
            it.op  = ($urandom_range(7) == 0) ? 4'(12 + $urandom_range(3)) : 4'($urandom_range(11));
            it.wds = 2'($urandom_range(3));
            it.we  = 1'($urandom_range(1));
            it.s1  = 2'($urandom_range(3));
            it.s2  = 2'($urandom_range(3));
            it.r1  = rnd_word();
            it.r2  = rnd_word();
            it.ext = rnd_word();
            it.sa  = 5'($urandom_range(31));
            it.wa  = 5'($urandom_range(31));
            issue(it);
        end

        // Reset in the middle of a multiply discards it and clears HI/LO.
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        @(negedge clk);
        drive(mk(4'd13, 2'b00, 2'd0, 2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 5'd0, 5'd0));
        @(negedge clk);
        drive(mfhi);
        repeat (10) @(posedge clk);
        #2;
        check("busy_before_reset", 32'(bus.stall_out), 32'd1);
        rst = 1'b1;
        #1;
        check_zero_outputs("mid_busy_reset");
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        md_left = 0;
        mon_en = 1'b1;
        issue(mfhi);
        issue(mflo);
        issue(mk(4'd1, 2'b00, 2'd0, 2'd1, 32'h10, 32'h0, 32'h3, 5'd0, 5'd12));

        for (int k = 0; k < 100 && sbq.size() > 0; k++) @(posedge clk);
        #5;
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d required=0 records left", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
